alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single 32-bit ALU between two requesters: port 0 is the main datapath and port 1 is the auxiliary/branch-compare unit.
- Arbitrates one operation per cycle with a valid/ready handshake.
- Drives the ALU operand and control inputs. The ALU's datapath path (alu_a/alu_b/alu_gin → alu_sum/alu_zout) is combinational.
- Registers the result into a tagged response. Keeps a separate {N,Z,V} status-flag register per requester, so one requester's operations never disturb the other's flags.

Parameters:
- WIDTH, 32, operand/result width; flag logic uses bit WIDTH-1 as sign.
- FIXED_PRIO, 0, 0 = round-robin between requesters; 1 = requester 0 always wins.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0's operation is accepted this cycle.
- req0_a  in  WIDTH  requester 0 operand a.
- req0_b  in  WIDTH  requester 0 operand b.
- req0_gin  in  4  requester 0 ALU control code.
- req1_valid, req1_ready, req1_a, req1_b, req1_gin  same as port 0, for requester 1.
- alu_a  out  WIDTH  operand a driven to the ALU.
- alu_b  out  WIDTH  operand b driven to the ALU.
- alu_gin  out  4  control code driven to the ALU.
- alu_sum  in  WIDTH  ALU result, combinational from alu_a/alu_b/alu_gin.
- alu_zout  in  1  ALU zero output.
- rsp_valid  out  1  one-cycle pulse; response fields are valid.
- rsp_id  out  1  requester that owns the response.
- rsp_data  out  WIDTH  registered result.
- rsp_err  out  1  the operation used an unsupported control code.
- flags0  out  3  requester 0 status flags {N,Z,V}.
- flags1  out  3  requester 1 status flags {N,Z,V}.

Behaviour:
- Legal control codes: 0010 ADD, 0110 SUB, 0111 SLT, 0000 AND, 0001 OR, 1010 NOR, 1001 XOR, 1000 PASS (result = a). Every other code is illegal.
- Grant logic (combinational): reqN_ready = grant to N. At most one ready per cycle. No response backpressure, so throughput is 1 operation/cycle.
- Round-robin state: last_id register.
  - Reset value 1, so requester 0 wins the first conflict.
  - On a conflict, grant !last_id.
  - last_id updates only when a grant occurs.
  - A lone requester is always granted.
- FIXED_PRIO=1: req0 wins every conflict and last_id is ignored.
- ALU drive: alu_a/alu_b/alu_gin are muxed from the granted requester in the same cycle. With no grant, all three are driven to 0.
- Capture, at the edge ending a grant cycle:
  - rsp_valid = 1.
  - rsp_id = granted id.
  - rsp_data = alu_sum, or 0 if the code is illegal.
  - rsp_err = illegal.
- Latency: handshake in cycle t; response visible in cycle t+1 only. rsp_valid returns to 0 with no grant. rsp_data/rsp_id hold their last values while rsp_valid = 0.
- Flag update: only the owner's flag register changes, on the same edge as the capture.
  - Z = alu_zout.
  - N = alu_sum[WIDTH-1].
  - V for ADD = a and b have the same sign and the result sign differs.
  - V for SUB = a and b have differing signs and the result sign differs from a.
  - V = 0 for all other legal ops.
  - Illegal code: flags of that requester remain unchanged.
- Reset: rsp_valid, rsp_id, rsp_data, rsp_err, flags0, flags1 = 0; last_id = 1. While reset is high, ready outputs are forced to 0. An operation presented in the reset cycle is dropped and is not replayed.
- A request held valid across cycles without ready stays pending. The requester must keep its operands stable until ready is seen.
- Simultaneous requests on consecutive cycles alternate grants strictly: 0,1,0,1…

Decomposition:
- Shared package alu_pkg:
  - Localparams for the eight ALU control codes: ALU_ADD, ALU_SUB, ALU_SLT, ALU_AND, ALU_OR, ALU_NOR, ALU_XOR, ALU_BRV.
  - FLAG_N/FLAG_Z/FLAG_V bit indices.
  - Function is_legal_gin.
- Sub-module rr_arb2: 2-way round-robin grant with last_id state and a fixed-priority option. The top level holds the muxing, capture, and flag registers.

Test Plan:
- Single request, ADD: req0 ADD a=5, b=7 → req0_ready=1 in cycle 0. Cycle 1: rsp_valid=1, rsp_id=0, rsp_data=12, flags0=000; flags1 unchanged.
- ADD overflow on port 1: req1 ADD a=0x7FFFFFFF, b=1 → rsp_data=0x80000000, flags1 {N,Z,V}=101. SUB 3−3 next → rsp_data=0, flags1=010.
- Sustained conflict: both valid for 4 cycles (FIXED_PRIO=0) → grants 0,1,0,1; rsp_id sequence 0,1,0,1, each one cycle later. With FIXED_PRIO=1 → req1 is never granted while req0 stays valid.
- SLT and illegal code: req0 SLT a=−1, b=2 → rsp_data=1. req0 gin=0011 → rsp_err=1, rsp_data=0, flags0 unchanged.
- Reset mid-operation: grant in cycle t, reset high in t+1 → rsp_valid=0, all flags 0, ready=0 during reset. First conflict after reset grants req0.
- Idle: no valid → alu_a/alu_b/alu_gin=0, rsp_valid=0, rsp_data holds its previous value.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control codes, flag bit positions and requester ids for the
// ALU sharing logic.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_NOR = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1001;
    localparam logic [3:0] ALU_BRV = 4'b1000;

    // Flag vector layout is {N,Z,V}
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_e;

    function automatic logic is_legal_gin(input logic [3:0] gin);
        case (gin)
            ALU_ADD, ALU_SUB, ALU_SLT, ALU_AND,
            ALU_OR, ALU_NOR, ALU_XOR, ALU_BRV: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: round-robin on conflicts (last winner loses), or fixed
// priority to requester 0. No grants are issued while reset is high.
module rr_arb2 import alu_pkg::*; #(
    parameter int FIXED_PRIO = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1
);

    req_id_e last_id;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (valid0 && valid1) begin
                if (FIXED_PRIO != 0 || last_id == REQ1) grant0 = 1'b1;
                else                                   grant1 = 1'b1;
            end else begin
                grant0 = valid0;
                grant1 = valid1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)       last_id <= REQ1;
        else if (grant0) last_id <= REQ0;
        else if (grant1) last_id <= REQ1;
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters, registering a tagged
// response and keeping an independent {N,Z,V} flag register per requester.
module alu_share_arbiter import alu_pkg::*; #(
    parameter int WIDTH      = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_gin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_gin,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_gin,
    input  logic [WIDTH-1:0] alu_sum,
    input  logic             alu_zout,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [2:0]       flags0,
    output logic [2:0]       flags1
);

    logic       grant0, grant1, any_grant, legal, ovf;
    logic       sa, sb, sr;
    logic [2:0] new_flags;

    rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
        .clk    (clk),
        .reset  (reset),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign any_grant  = grant0 | grant1;

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_gin = '0;
        if (grant0) begin
            alu_a   = req0_a;
            alu_b   = req0_b;
            alu_gin = req0_gin;
        end else if (grant1) begin
            alu_a   = req1_a;
            alu_b   = req1_b;
            alu_gin = req1_gin;
        end
    end

    assign legal = is_legal_gin(alu_gin);
    assign sa    = alu_a[WIDTH-1];
    assign sb    = alu_b[WIDTH-1];
    assign sr    = alu_sum[WIDTH-1];

    always_comb begin
        case (alu_gin)
            ALU_ADD: ovf = (sa == sb) && (sr != sa);
            ALU_SUB: ovf = (sa != sb) && (sr != sa);
            default: ovf = 1'b0;
        endcase
        new_flags         = '0;
        new_flags[FLAG_N] = sr;
        new_flags[FLAG_Z] = alu_zout;
        new_flags[FLAG_V] = ovf;
    end

    // Response fields hold between grants; only rsp_valid pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            flags0    <= '0;
            flags1    <= '0;
        end else begin
            rsp_valid <= any_grant;
            if (any_grant) begin
                rsp_id   <= grant1;
                rsp_data <= legal ? alu_sum : '0;
                rsp_err  <= ~legal;
                if (legal) begin
                    if (grant1) flags1 <= new_flags;
                    else        flags0 <= new_flags;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: the driver predicts grants and
// responses from a reference model, a separate monitor checks responses.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    always #5 clk = ~clk;

    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_gin = '0, req1_gin = '0;
    logic [31:0] alu_a, alu_b, alu_sum;
    logic [3:0]  alu_gin;
    logic        alu_zout;
    logic        rsp_valid, rsp_id, rsp_err;
    logic [31:0] rsp_data;
    logic [2:0]  flags0, flags1;

    // Fixed-priority instance
    logic        f0_valid = 1'b0, f1_valid = 1'b0;
    logic        f0_ready, f1_ready;
    logic [31:0] f_a = 32'd9, f_b = 32'd4;
    logic [31:0] f_alu_a, f_alu_b, f_alu_sum;
    logic [3:0]  f_alu_gin;
    logic        f_alu_zout;
    logic        f_rsp_valid, f_rsp_id, f_rsp_err;
    logic [31:0] f_rsp_data;
    logic [2:0]  f_flags0, f_flags1;

    function automatic logic [31:0] tb_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] g);
        case (g)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b1010: return ~(a | b);
            4'b1001: return a ^ b;
            4'b1000: return a;
            default: return (a ^ 32'h5A5A_5A5A) | 32'h1;
        endcase
    endfunction

    assign alu_sum    = tb_alu(alu_a, alu_b, alu_gin);
    assign alu_zout   = (alu_sum == 32'd0);
    assign f_alu_sum  = tb_alu(f_alu_a, f_alu_b, f_alu_gin);
    assign f_alu_zout = (f_alu_sum == 32'd0);

    alu_share_arbiter #(.WIDTH(32), .FIXED_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_gin(req0_gin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_gin(req1_gin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_gin(alu_gin), .alu_sum(alu_sum), .alu_zout(alu_zout),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .flags0(flags0), .flags1(flags1)
    );

    alu_share_arbiter #(.WIDTH(32), .FIXED_PRIO(1)) dut_fixed (
        .clk(clk), .reset(reset),
        .req0_valid(f0_valid), .req0_ready(f0_ready), .req0_a(f_a), .req0_b(f_b), .req0_gin(4'b0010),
        .req1_valid(f1_valid), .req1_ready(f1_ready), .req1_a(f_b), .req1_b(f_a), .req1_gin(4'b0110),
        .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_gin(f_alu_gin), .alu_sum(f_alu_sum), .alu_zout(f_alu_zout),
        .rsp_valid(f_rsp_valid), .rsp_id(f_rsp_id), .rsp_data(f_rsp_data), .rsp_err(f_rsp_err),
        .flags0(f_flags0), .flags1(f_flags1)
    );

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        err;
        logic [2:0]  f0;
        logic [2:0]  f1;
    } exp_t;

    exp_t sbq[$];
    int compared = 0;
    int mismatched = 0;

    // Reference model state
    logic        pv[2];
    logic [31:0] pa[2], pb[2];
    logic [3:0]  pg[2];
    int          m_last;
    logic [2:0]  m_flags[2];
    logic [3:0]  codes[8] = '{4'b0010, 4'b0110, 4'b0111, 4'b0000, 4'b0001, 4'b1010, 4'b1001, 4'b1000};

    // Last response the monitor has seen, for checking hold behaviour
    logic        mon_id = 1'b0;
    logic [31:0] mon_data = '0;
    logic [2:0]  mon_f0 = '0, mon_f1 = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_op(input int w, input logic [31:0] a, input logic [31:0] b,
                                      input logic [3:0] g);
        exp_t   e;
        longint sa, sb, s;
        logic [31:0] res;
        logic   v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.id  = (w == 1);
        e.err = !(g inside {codes});
        if (e.err) begin
            e.data = 32'd0;
        end else begin
            res = tb_alu(a, b, g);
            v = 1'b0;
            if (g == 4'b0010) begin
                s = sa + sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end else if (g == 4'b0110) begin
                s = sa - sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            e.data = res;
            m_flags[w] = {res[31], res == 32'd0, v};
        end
        e.f0 = m_flags[0];
        e.f1 = m_flags[1];
        return e;
    endfunction

    task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b, input logic [3:0] g);
        pv[k] = 1'b1;
        pa[k] = a;
        pb[k] = b;
        pg[k] = g;
    endtask

    task automatic drive_cycle();
        int w;
        exp_t e;
        req0_valid = pv[0]; req0_a = pa[0]; req0_b = pb[0]; req0_gin = pg[0];
        req1_valid = pv[1]; req1_a = pa[1]; req1_b = pb[1]; req1_gin = pg[1];
        @(negedge clk);
        if (pv[0] && pv[1]) w = (m_last == 1) ? 0 : 1;
        else if (pv[0])     w = 0;
        else if (pv[1])     w = 1;
        else                w = -1;
        chk("req0_ready", req0_ready, w == 0);
        chk("req1_ready", req1_ready, w == 1);
        if (w < 0) begin
            chk("idle_alu_a", alu_a, 0);
            chk("idle_alu_b", alu_b, 0);
            chk("idle_alu_gin", alu_gin, 0);
        end else begin
            e = model_op(w, pa[w], pb[w], pg[w]);
            sbq.push_back(e);
            m_last = w;
            pv[w] = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd11; req0_b = 32'd22; req0_gin = 4'b0010;
        req1_valid = 1'b1; req1_a = 32'd33; req1_b = 32'd44; req1_gin = 4'b0110;
        @(negedge clk);
        chk("reset_ready0", req0_ready, 0);
        chk("reset_ready1", req1_ready, 0);
        @(posedge clk);
        #1;
        sbq.delete();
        pv[0] = 1'b0; pv[1] = 1'b0;
        m_last = 1;
        m_flags[0] = '0; m_flags[1] = '0;
        mon_id = 1'b0; mon_data = '0; mon_f0 = '0; mon_f1 = '0;
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_flags0", flags0, 0);
        chk("reset_flags1", flags1, 0);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(5))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'h0000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (rsp_valid) begin
                    if (sbq.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response (t=%0t)", $time);
                    end else begin
                        e = sbq.pop_front();
                        chk("rsp_id", rsp_id, e.id);
                        chk("rsp_data", rsp_data, e.data);
                        chk("rsp_err", rsp_err, e.err);
                        chk("flags0", flags0, e.f0);
                        chk("flags1", flags1, e.f1);
                        mon_id = e.id; mon_data = e.data; mon_f0 = e.f0; mon_f1 = e.f1;
                    end
                end else begin
                    chk("hold_rsp_data", rsp_data, mon_data);
                    chk("hold_rsp_id", rsp_id, mon_id);
                    chk("hold_flags0", flags0, mon_f0);
                    chk("hold_flags1", flags1, mon_f1);
                end
            end
        end
    end

    // Driver
    initial begin
        pv[0] = 1'b0; pv[1] = 1'b0;
        pa[0] = '0; pa[1] = '0; pb[0] = '0; pb[1] = '0; pg[0] = '0; pg[1] = '0;
        m_last = 1;
        m_flags[0] = '0; m_flags[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        apply_reset();

        // Single ADD, then idle
        set_req(0, 32'd5, 32'd7, 4'b0010);
        drive_cycle();
        drive_cycle();

        // Overflow and zero on port 1
        set_req(1, 32'h7FFF_FFFF, 32'd1, 4'b0010);
        drive_cycle();
        set_req(1, 32'd3, 32'd3, 4'b0110);
        drive_cycle();

        // Sustained conflict
        for (int i = 0; i < 4; i++) begin
            if (!pv[0]) set_req(0, $urandom, $urandom, codes[$urandom_range(7)]);
            if (!pv[1]) set_req(1, $urandom, $urandom, codes[$urandom_range(7)]);
            drive_cycle();
        end
        for (int i = 0; i < 4 && (pv[0] || pv[1]); i++) drive_cycle();

        // SLT and illegal code
        set_req(0, 32'hFFFF_FFFF, 32'd2, 4'b0111);
        drive_cycle();
        set_req(0, 32'd8, 32'd9, 4'b0011);
        drive_cycle();
        drive_cycle();

        // Reset right after a grant, then first conflict goes to requester 0
        set_req(0, 32'd100, 32'd1, 4'b0110);
        drive_cycle();
        apply_reset();
        set_req(0, 32'd1, 32'd2, 4'b0001);
        set_req(1, 32'd4, 32'd4, 4'b1001);
        drive_cycle();
        drive_cycle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (!pv[k] && $urandom_range(9) < 6)
                    set_req(k, pick_operand(), pick_operand(),
                            ($urandom_range(4) == 0) ? 4'($urandom) : codes[$urandom_range(7)]);
            end
            drive_cycle();
        end
        for (int i = 0; i < 4 && (pv[0] || pv[1]); i++) drive_cycle();
        drive_cycle();
        drive_cycle();
        chk("scoreboard_drained", sbq.size(), 0);

        // Fixed priority: requester 1 only wins while requester 0 is idle
        f1_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            f0_valid = ((i % 7) != 6);
            @(negedge clk);
            chk("fixed_ready0", f0_ready, f0_valid);
            chk("fixed_ready1", f1_ready, !f0_valid);
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
